// File: rtl/ssd_day_counter_if.sv
// rtl/ssd_day_counter_if.sv - control and display bundle for ssd_day_counter
//
// Purpose: groups the day counter's tick/SET controls and its BCD/segment
// outputs so the counter and its driver share one connection.
// Signals:
//   dsyn_rst_n         display-only reset, active-low
//   day_tick           one-cycle end-of-day pulse
//   set_en             SET mode request (level)
//   set_inc, set_dec   one-cycle adjust pulses in SET
//   day_bcd            registered BCD count, digit 0 in [3:0]
//   ssd_day            segment patterns, digit k in [7k+6:7k]
//   carry_out          one-cycle pulse on DAY_MAX -> DAY_MIN tick wrap
//   set_mode           high while in SET
// Modports: master drives the controls, slave is the counter.

interface ssd_day_counter_if #(
  parameter int DIGITS = 2
);
  logic                  dsyn_rst_n;
  logic                  day_tick;
  logic                  set_en;
  logic                  set_inc;
  logic                  set_dec;
  logic [4*DIGITS-1:0]   day_bcd;
  logic [7*DIGITS-1:0]   ssd_day;
  logic                  carry_out;
  logic                  set_mode;

  modport master (
    output dsyn_rst_n, day_tick, set_en, set_inc, set_dec,
    input  day_bcd, ssd_day, carry_out, set_mode
  );

  modport slave (
    input  dsyn_rst_n, day_tick, set_en, set_inc, set_dec,
    output day_bcd, ssd_day, carry_out, set_mode
  );
endinterface

// File: rtl/ssd_day_counter.sv
// rtl/ssd_day_counter.sv - parametrised BCD day counter with SET mode and 7-segment output
//
// Purpose: counts end-of-day ticks in BCD over DAY_MIN..DAY_MAX, lets the user
// adjust the day in SET mode with a blinking display, and defers at most one
// tick that arrives while in SET.
// Ports:
//   clk     single clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     ssd_day_counter_if.slave (tick/SET inputs, BCD/segment outputs)
// Build option: SSD_DAY_LZ_BLANK_EN blanks leading-zero digits (digit 0 never).

`ifndef ZERO
`define ZERO  7'h3F
`endif
`ifndef ONE
`define ONE   7'h06
`endif
`ifndef TWO
`define TWO   7'h5B
`endif
`ifndef THREE
`define THREE 7'h4F
`endif
`ifndef FOUR
`define FOUR  7'h66
`endif
`ifndef FIVE
`define FIVE  7'h6D
`endif
`ifndef SIX
`define SIX   7'h7D
`endif
`ifndef SEVEN
`define SEVEN 7'h07
`endif
`ifndef EIGHT
`define EIGHT 7'h7F
`endif
`ifndef NINE
`define NINE  7'h6F
`endif

module ssd_day_counter #(
  parameter int DIGITS    = 2,
  parameter int DAY_MIN   = 1,
  parameter int DAY_MAX   = 31,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  ssd_day_counter_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  function automatic logic [W-1:0] to_bcd(input int v);
    int t;
    logic [W-1:0] r;
    t = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MIN_BCD = to_bcd(DAY_MIN);
  localparam logic [W-1:0] MAX_BCD = to_bcd(DAY_MAX);

  // Ripple +1 across BCD digits: a digit at 9 rolls to 0 and carries on.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple -1 across BCD digits: a digit at 0 rolls to 9 and borrows on.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return `ZERO;
      4'd1:    return `ONE;
      4'd2:    return `TWO;
      4'd3:    return `THREE;
      4'd4:    return `FOUR;
      4'd5:    return `FIVE;
      4'd6:    return `SIX;
      4'd7:    return `SEVEN;
      4'd8:    return `EIGHT;
      4'd9:    return `NINE;
      default: return 7'd0;
    endcase
  endfunction

  typedef enum logic {ST_RUN = 1'b0, ST_SET = 1'b1} state_t;

  state_t          r_state, w_next_state;
  logic [W-1:0]    r_day, w_day_next;
  logic            r_pending, w_pending_next;
  logic            r_carry, w_carry_next;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_blink_on;
  logic [W-1:0]    w_inc_val, w_dec_val;
  logic            w_at_max;
  logic [7*DIGITS-1:0] w_ssd;

  assign w_at_max  = (r_day == MAX_BCD);
  assign w_inc_val = w_at_max ? MIN_BCD : bcd_inc(r_day);
  assign w_dec_val = (r_day == MIN_BCD) ? MAX_BCD : bcd_dec(r_day);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_day     <= MIN_BCD;
      r_pending <= 1'b0;
      r_carry   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_day     <= w_day_next;
      r_pending <= w_pending_next;
      r_carry   <= w_carry_next;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_day_next     = r_day;
    w_pending_next = r_pending;
    w_carry_next   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.set_en) w_next_state = ST_SET;
        // A leftover deferred tick and a fresh tick together still give only
        // one step; the other stays pending for the next cycle.
        if (bus.day_tick || r_pending) begin
          w_day_next     = w_inc_val;
          w_carry_next   = w_at_max;
          w_pending_next = bus.day_tick & r_pending;
        end
      end
      default: begin
        if (!bus.set_en) begin
          w_next_state   = ST_RUN;
          // A tick on the exit edge itself is kept for the following cycle.
          w_pending_next = bus.day_tick;
          if (r_pending) begin
            w_day_next   = w_inc_val;
            w_carry_next = w_at_max;
          end
        end else begin
          w_pending_next = r_pending | bus.day_tick;
          if (bus.set_inc && !bus.set_dec)      w_day_next = w_inc_val;
          else if (bus.set_dec && !bus.set_inc) w_day_next = w_dec_val;
        end
      end
    endcase
  end

  // Blink runs only while staying in SET; any other edge restarts it visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_state == ST_SET && w_next_state == ST_SET) begin
      if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end else begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end
  end

  always_comb begin
    logic [6:0] w_seg;
`ifdef SSD_DAY_LZ_BLANK_EN
    logic w_lead;
    w_lead = 1'b1;
`endif
    w_ssd = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_seg = seg7(r_day[4*k +: 4]);
`ifdef SSD_DAY_LZ_BLANK_EN
      if (k != 0 && w_lead && r_day[4*k +: 4] == 4'd0) w_seg = 7'd0;
      w_lead = w_lead & (r_day[4*k +: 4] == 4'd0);
`endif
      w_ssd[7*k +: 7] = w_seg;
    end
    if (!bus.dsyn_rst_n || !r_blink_on) w_ssd = '0;
  end

  assign bus.day_bcd   = r_day;
  assign bus.ssd_day   = w_ssd;
  assign bus.carry_out = r_carry;
  assign bus.set_mode  = (r_state == ST_SET);

endmodule

// File: tb/tb_ssd_day_counter.sv
// tb/tb_ssd_day_counter.sv - self-checking bench for ssd_day_counter

module tb_ssd_day_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ssd_day_counter_if #(.DIGITS(2)) a_if ();
  ssd_day_counter_if #(.DIGITS(3)) b_if ();

  ssd_day_counter #(.DIGITS(2), .DAY_MIN(1), .DAY_MAX(31), .BLINK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if)
  );
  ssd_day_counter #(.DIGITS(3), .DAY_MIN(0), .DAY_MAX(999), .BLINK_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if)
  );

  typedef struct {
    logic       tick, set_en, inc, dec;
    logic [7:0] bcd;
    logic       carry, mode, vis;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  function automatic logic [13:0] exp_a(input logic [7:0] bcd);
    logic [6:0] hi;
    hi = seg_of(bcd[7:4]);
`ifdef SSD_DAY_LZ_BLANK_EN
    if (bcd[7:4] == 4'd0) hi = 7'd0;
`endif
    return {hi, seg_of(bcd[3:0])};
  endfunction

  function automatic logic [20:0] exp_b(input logic [11:0] bcd);
    logic [6:0] d2, d1;
    d2 = seg_of(bcd[11:8]);
    d1 = seg_of(bcd[7:4]);
`ifdef SSD_DAY_LZ_BLANK_EN
    if (bcd[11:8] == 4'd0) d2 = 7'd0;
    if (bcd[11:4] == 8'd0) d1 = 7'd0;
`endif
    return {d2, d1, seg_of(bcd[3:0])};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_a(input int n);
    a_if.day_tick = 1'b1;
    repeat (n) step();
    a_if.day_tick = 1'b0;
  endtask

  task automatic tick_b(input int n);
    b_if.day_tick = 1'b1;
    repeat (n) step();
    b_if.day_tick = 1'b0;
  endtask

  initial begin
    //           tick set inc dec  bcd   c  m  vis
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h31, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1};

    a_if.dsyn_rst_n = 1'b1; a_if.day_tick = 1'b0; a_if.set_en = 1'b0;
    a_if.set_inc = 1'b0; a_if.set_dec = 1'b0;
    b_if.dsyn_rst_n = 1'b1; b_if.day_tick = 1'b0; b_if.set_en = 1'b0;
    b_if.set_inc = 1'b0; b_if.set_dec = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_bcd", a_if.day_bcd, 8'h01);
    chk("rst_carry", a_if.carry_out, 1'b0);
    chk("rst_mode", a_if.set_mode, 1'b0);
    chk("rst_ssd", a_if.ssd_day, exp_a(8'h01));
    a_if.dsyn_rst_n = 1'b0;
    #1;
    chk("rst_ssd_dsyn", a_if.ssd_day, 14'd0);
    a_if.dsyn_rst_n = 1'b1;
    chk("rst_b_bcd", b_if.day_bcd, 12'h000);
    chk("rst_b_ssd", b_if.ssd_day, exp_b(12'h000));
    rst_n = 1'b1;
    step();

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      a_if.day_tick = tbl[i].tick; a_if.set_en = tbl[i].set_en;
      a_if.set_inc = tbl[i].inc;   a_if.set_dec = tbl[i].dec;
      step();
      chk($sformatf("vec%0d_bcd", i), a_if.day_bcd, tbl[i].bcd);
      chk($sformatf("vec%0d_carry", i), a_if.carry_out, tbl[i].carry);
      chk($sformatf("vec%0d_mode", i), a_if.set_mode, tbl[i].mode);
      chk($sformatf("vec%0d_ssd", i), a_if.ssd_day,
          tbl[i].vis ? exp_a(tbl[i].bcd) : 14'd0);
    end
    a_if.day_tick = 1'b0; a_if.set_en = 1'b0; a_if.set_inc = 1'b0; a_if.set_dec = 1'b0;

    // Wrap 31 -> 01 with a one-cycle carry
    tick_a(29);
    chk("wrap_pre_bcd", a_if.day_bcd, 8'h31);
    tick_a(1);
    chk("wrap_bcd", a_if.day_bcd, 8'h01);
    chk("wrap_carry", a_if.carry_out, 1'b1);
    step();
    chk("wrap_carry_clr", a_if.carry_out, 1'b0);

    // Deferred tick: several ticks in SET give one increment on exit
    a_if.set_en = 1'b1; step();
    a_if.set_inc = 1'b1; repeat (9) step(); a_if.set_inc = 1'b0;
    chk("def_set10", a_if.day_bcd, 8'h10);
    tick_a(1); step(); tick_a(1); tick_a(1);
    chk("def_held", a_if.day_bcd, 8'h10);
    a_if.set_en = 1'b0; step();
    chk("def_exit_bcd", a_if.day_bcd, 8'h11);
    chk("def_exit_mode", a_if.set_mode, 1'b0);
    repeat (2) step();
    chk("def_no_more", a_if.day_bcd, 8'h11);

    // Tick on the exit edge itself, with a pending tick already held
    a_if.set_en = 1'b1; step();
    tick_a(1);
    chk("exit_tick_hold", a_if.day_bcd, 8'h11);
    a_if.set_en = 1'b0; a_if.day_tick = 1'b1; step(); a_if.day_tick = 1'b0;
    chk("exit_tick_first", a_if.day_bcd, 8'h12);
    step();
    chk("exit_tick_second", a_if.day_bcd, 8'h13);
    step();
    chk("exit_tick_stable", a_if.day_bcd, 8'h13);

    // Deferred tick that wraps fires carry on exit
    a_if.set_en = 1'b1; step();
    a_if.set_dec = 1'b1; repeat (13) step(); a_if.set_dec = 1'b0;
    chk("defwrap_pre", a_if.day_bcd, 8'h31);
    tick_a(1);
    a_if.set_en = 1'b0; step();
    chk("defwrap_bcd", a_if.day_bcd, 8'h01);
    chk("defwrap_carry", a_if.carry_out, 1'b1);
    step();
    chk("defwrap_carry_clr", a_if.carry_out, 1'b0);

    // Blink: 4 visible, 4 blank, visible again
    a_if.set_en = 1'b1; step();
    for (int j = 0; j < 12; j++) begin
      chk($sformatf("blink%0d", j), a_if.ssd_day,
          ((j < 4) || (j >= 8)) ? exp_a(8'h01) : 14'd0);
      step();
    end
    a_if.set_en = 1'b0; step();
    chk("blink_exit_vis", a_if.ssd_day, exp_a(8'h01));

    // Display-only reset leaves counting alone
    a_if.dsyn_rst_n = 1'b0;
    tick_a(1);
    chk("dsyn_bcd", a_if.day_bcd, 8'h02);
    chk("dsyn_ssd", a_if.ssd_day, 14'd0);
    a_if.dsyn_rst_n = 1'b1;
    #1;
    chk("dsyn_release", a_if.ssd_day, exp_a(8'h02));

    // Asynchronous reset mid-SET discards a pending tick
    a_if.set_en = 1'b1; step();
    tick_a(1);
    a_if.set_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_bcd", a_if.day_bcd, 8'h01);
    chk("arst_mode", a_if.set_mode, 1'b0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("arst_no_pending", a_if.day_bcd, 8'h01);

    // Three-digit instance: leading zeros, ripple, full-range wrap
    tick_b(7);
    chk("b_seven_bcd", b_if.day_bcd, 12'h007);
    chk("b_seven_ssd", b_if.ssd_day, exp_b(12'h007));
    tick_b(92);
    chk("b_099", b_if.day_bcd, 12'h099);
    tick_b(1);
    chk("b_ripple", b_if.day_bcd, 12'h100);
    chk("b_ripple_ssd", b_if.ssd_day, exp_b(12'h100));
    tick_b(899);
    chk("b_999", b_if.day_bcd, 12'h999);
    chk("b_999_carry", b_if.carry_out, 1'b0);
    tick_b(1);
    chk("b_wrap_bcd", b_if.day_bcd, 12'h000);
    chk("b_wrap_carry", b_if.carry_out, 1'b1);
    b_if.set_en = 1'b1; step();
    chk("b_wrap_carry_clr", b_if.carry_out, 1'b0);
    b_if.set_dec = 1'b1; step(); b_if.set_dec = 1'b0;
    chk("b_dec_wrap", b_if.day_bcd, 12'h999);
    chk("b_dec_carry", b_if.carry_out, 1'b0);
    b_if.set_en = 1'b0; step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
